// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter and strobe sequencer for the Ram2Ddr SRAM-style port.
// One 32-bit access at a time: IDLE -> ACCESS -> RECOVER, all outputs registered.
module ram_port_arbiter #(
    parameter int ACCESS_CYCLES  = 27,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic        clk_100MHz,
    input  logic        rstn,
    input  logic        req0,
    input  logic        we0,
    input  logic [26:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [26:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [26:0] ram_a,
    output logic [31:0] ram_dq_i,
    input  logic [31:0] ram_dq_o,
    output logic        ram_cen,
    output logic        ram_oen,
    output logic        ram_wen
);

    localparam int MAX_CYC = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             we_q, we_d;
    logic             last_q, last_d;
    logic [26:0]      ram_a_q, ram_a_d;
    logic [31:0]      ram_dq_i_q, ram_dq_i_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             cen_q, cen_d;
    logic             oen_q, oen_d;
    logic             wen_q, wen_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic             ack_fire;

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            last_q     <= 1'b1;
            ram_a_q    <= '0;
            ram_dq_i_q <= '0;
            rd_data_q  <= '0;
            cen_q      <= 1'b1;
            oen_q      <= 1'b1;
            wen_q      <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            last_q     <= last_d;
            ram_a_q    <= ram_a_d;
            ram_dq_i_q <= ram_dq_i_d;
            rd_data_q  <= rd_data_d;
            cen_q      <= cen_d;
            oen_q      <= oen_d;
            wen_q      <= wen_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    // Requester 1 wins only when alone or when requester 0 was served last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = req1 && (!req0 || !last_q);
                    last_d  = gnt_d;
                    we_d    = gnt_d ? we1 : we0;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == ACC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered pins line up with it.
    always_comb begin
        ram_a_d    = ram_a_q;
        ram_dq_i_d = ram_dq_i_q;
        rd_data_d  = rd_data_q;
        if (state_q == S_IDLE && state_d == S_ACCESS) begin
            ram_a_d    = gnt_d ? addr1 : addr0;
            ram_dq_i_d = gnt_d ? wdata1 : wdata0;
        end
        if (state_q == S_ACCESS && state_d == S_RECOVER && !we_q) begin
            rd_data_d = ram_dq_o;
        end
        cen_d    = (state_d != S_ACCESS);
        oen_d    = !(state_d == S_ACCESS && !we_d);
        wen_d    = !(state_d == S_ACCESS && we_d);
        ack_fire = (state_d == S_RECOVER) && (cnt_d == REC_LAST);
        ack0_d   = ack_fire && !gnt_d;
        ack1_d   = ack_fire && gnt_d;
        busy_d   = (state_d != S_IDLE);
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign ram_a    = ram_a_q;
    assign ram_dq_i = ram_dq_i_q;
    assign ram_cen  = cen_q;
    assign ram_oen  = oen_q;
    assign ram_wen  = wen_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: default timing instance plus a 1/1-cycle instance.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req0, we0, req1, we1;
    logic [26:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [31:0] rd_data;
    logic [26:0] ram_a;
    logic [31:0] ram_dq_i, ram_dq_o;
    logic        ram_cen, ram_oen, ram_wen;

    logic        f_req0, f_we0, f_req1, f_we1;
    logic [26:0] f_addr0, f_addr1;
    logic [31:0] f_wdata0, f_wdata1;
    logic        f_ack0, f_ack1, f_busy;
    logic [31:0] f_rd_data;
    logic [26:0] f_ram_a;
    logic [31:0] f_ram_dq_i, f_ram_dq_o;
    logic        f_ram_cen, f_ram_oen, f_ram_wen;

    ram_port_arbiter dut (
        .clk_100MHz(clk), .rstn(rstn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rd_data(rd_data), .busy(busy), .ram_a(ram_a), .ram_dq_i(ram_dq_i),
        .ram_dq_o(ram_dq_o), .ram_cen(ram_cen), .ram_oen(ram_oen), .ram_wen(ram_wen)
    );

    ram_port_arbiter #(.ACCESS_CYCLES(1), .RECOVER_CYCLES(1)) dut_fast (
        .clk_100MHz(clk), .rstn(rstn),
        .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0), .ack0(f_ack0),
        .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .ack1(f_ack1),
        .rd_data(f_rd_data), .busy(f_busy), .ram_a(f_ram_a), .ram_dq_i(f_ram_dq_i),
        .ram_dq_o(f_ram_dq_o), .ram_cen(f_ram_cen), .ram_oen(f_ram_oen), .ram_wen(f_ram_wen)
    );

    // Small SRAM model: writes land on the edge while CEn/WEn are low.
    logic [31:0] mem [0:255];
    always @(posedge clk) if (!ram_cen && !ram_wen) mem[ram_a[7:0]] <= ram_dq_i;
    assign ram_dq_o   = (!ram_cen && !ram_oen) ? mem[ram_a[7:0]] : 32'hDEADBEEF;
    assign f_ram_dq_o = (!f_ram_cen && !f_ram_oen) ? 32'h00005A5A : 32'hDEADBEEF;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int obs_cen_low, obs_oen_low, obs_wen_low, obs_first_low, obs_both_low;
    int obs_ack0_cnt, obs_ack1_cnt, obs_ack_cyc, obs_a_bad, obs_d_bad, obs_busy1, obs_busy_end;
    logic [31:0] obs_rd_at_ack;

    // Cycle 1 is the first cycle after the edge that samples the request.
    task automatic observe(input int ncyc, input logic [26:0] ea, input logic [31:0] ed, input int drop_c);
        obs_cen_low = 0; obs_oen_low = 0; obs_wen_low = 0; obs_first_low = 0; obs_both_low = 0;
        obs_ack0_cnt = 0; obs_ack1_cnt = 0; obs_ack_cyc = 0; obs_a_bad = 0; obs_d_bad = 0;
        obs_busy1 = 0; obs_busy_end = 0; obs_rd_at_ack = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == drop_c) begin req0 = 0; req1 = 0; end
            if (c == 1) obs_busy1 = int'(busy);
            if (c == ncyc) obs_busy_end = int'(busy);
            if (!ram_cen) begin
                obs_cen_low++;
                if (obs_first_low == 0) obs_first_low = c;
                if (ram_a !== ea) obs_a_bad++;
                if (ram_dq_i !== ed) obs_d_bad++;
            end
            if (!ram_oen) obs_oen_low++;
            if (!ram_wen) obs_wen_low++;
            if (!ram_oen && !ram_wen) obs_both_low++;
            if (ack0) obs_ack0_cnt++;
            if (ack1) obs_ack1_cnt++;
            if ((ack0 || ack1) && obs_ack_cyc == 0) begin
                obs_ack_cyc = c;
                obs_rd_at_ack = rd_data;
                req0 = 0; req1 = 0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [4];
        int nacks, run, min_gap, seen_low, ack_prev, ack_consec, both_low, nack_f, nlow_f;
        int bad_low_ph, bad_ack_ph, f_wen_lo, f_oen_lo;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        rstn = 0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        f_req0 = 0; f_we0 = 0; f_addr0 = '0; f_wdata0 = '0;
        f_req1 = 0; f_we1 = 0; f_addr1 = '0; f_wdata1 = '0;
        repeat (3) @(negedge clk);
        check("rst_cen", ram_cen, 1); check("rst_oen", ram_oen, 1); check("rst_wen", ram_wen, 1);
        check("rst_ack", {ack1, ack0}, 0); check("rst_busy", busy, 0);
        check("rst_ram_a", ram_a, 0); check("rst_dq_i", ram_dq_i, 0); check("rst_rd", rd_data, 0);
        rstn = 1;
        @(negedge clk);

        // T1: requester 0 write
        we0 = 1; addr0 = 27'd1024; wdata0 = 32'h12345678; req0 = 1;
        observe(34, 27'd1024, 32'h12345678, 0);
        check("t1_cen_low", obs_cen_low, 27); check("t1_wen_low", obs_wen_low, 27);
        check("t1_oen_low", obs_oen_low, 0); check("t1_first_low", obs_first_low, 1);
        check("t1_ack0_cyc", obs_ack_cyc, 30); check("t1_ack0_cnt", obs_ack0_cnt, 1);
        check("t1_ack1_cnt", obs_ack1_cnt, 0); check("t1_a_held", obs_a_bad, 0);
        check("t1_d_held", obs_d_bad, 0); check("t1_busy1", obs_busy1, 1);
        check("t1_busy_end", obs_busy_end, 0);

        // T2: requester 1 read of the same word
        we1 = 0; addr1 = 27'd1024; wdata1 = 32'h0; req1 = 1;
        observe(34, 27'd1024, 32'h0, 0);
        check("t2_oen_low", obs_oen_low, 27); check("t2_cen_low", obs_cen_low, 27);
        check("t2_wen_low", obs_wen_low, 0); check("t2_ack1_cyc", obs_ack_cyc, 30);
        check("t2_ack1_cnt", obs_ack1_cnt, 1); check("t2_ack0_cnt", obs_ack0_cnt, 0);
        check("t2_rd_data", obs_rd_at_ack, 32'h12345678); check("t2_a_held", obs_a_bad, 0);

        // T3: contention, four accesses
        we0 = 1; addr0 = 27'd16; wdata0 = 32'h100; we1 = 1; addr1 = 27'd32; wdata1 = 32'h200;
        req0 = 1; req1 = 1;
        nacks = 0; run = 0; min_gap = 999; seen_low = 0; ack_prev = 0; ack_consec = 0; both_low = 0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (ram_cen && ram_oen && ram_wen) run++;
            else begin
                if (seen_low != 0 && run > 0 && run < min_gap) min_gap = run;
                run = 0; seen_low = 1;
            end
            if (ack0 && ack1) both_low++;
            if (!ram_oen && !ram_wen) both_low++;
            if (ack0 || ack1) begin
                if (ack_prev != 0) ack_consec++;
                if (nacks < 4) order[nacks] = ack1 ? 1 : 0;
                nacks++;
                if (nacks == 4) begin req0 = 0; req1 = 0; end
            end
            ack_prev = int'(ack0 || ack1);
        end
        check("t3_nacks", nacks, 4);
        check("t3_order0", order[0], 0); check("t3_order1", order[1], 1);
        check("t3_order2", order[2], 0); check("t3_order3", order[3], 1);
        check("t3_ack_1cyc", ack_consec, 0); check("t3_exclusive", both_low, 0);
        check("t3_gap_ge3", (min_gap >= 3 && min_gap != 999), 1);
        check("t3_mem_wr1", mem[1024 % 256 + 32 - 0], 32'h200);

        // T4: reset during access cycle 10
        we0 = 1; addr0 = 27'd7; wdata0 = 32'h77; req0 = 1;
        repeat (10) @(negedge clk);
        check("t4_in_access", ram_cen, 0);
        #2 rstn = 0;
        #1;
        check("t4_cen", ram_cen, 1); check("t4_oen", ram_oen, 1); check("t4_wen", ram_wen, 1);
        check("t4_busy", busy, 0);
        req0 = 0;
        nacks = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (c == 3) rstn = 1;
            if (ack0 || ack1) nacks++;
        end
        check("t4_no_ack", nacks, 0);
        we0 = 0; addr0 = 27'd1024; wdata0 = 32'h0; we1 = 0; addr1 = 27'd5; wdata1 = 32'h0;
        req0 = 1; req1 = 1;
        observe(34, 27'd1024, 32'h0, 0);
        check("t4_first_ack0", obs_ack0_cnt, 1); check("t4_no_ack1", obs_ack1_cnt, 0);
        check("t4_ack_cyc", obs_ack_cyc, 30); check("t4_rd", obs_rd_at_ack, 32'h12345678);

        // T6: one-cycle request pulse, then read-back by requester 1
        we0 = 1; addr0 = 27'd5; wdata0 = 32'hCAFEF00D; req0 = 1;
        observe(34, 27'd5, 32'hCAFEF00D, 1);
        check("t6_cen_low", obs_cen_low, 27); check("t6_wen_low", obs_wen_low, 27);
        check("t6_ack0_cyc", obs_ack_cyc, 30); check("t6_ack0_cnt", obs_ack0_cnt, 1);
        we1 = 0; addr1 = 27'd5; wdata1 = 32'h0; req1 = 1;
        observe(34, 27'd5, 32'h0, 0);
        check("t6_readback", obs_rd_at_ack, 32'hCAFEF00D); check("t6_rb_ack1", obs_ack1_cnt, 1);

        // T5: 1/1 timing, requester 0 held for four accesses
        f_we0 = 0; f_addr0 = 27'd3; f_req0 = 1;
        nack_f = 0; nlow_f = 0; bad_low_ph = 0; bad_ack_ph = 0; f_wen_lo = 0; f_oen_lo = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!f_ram_cen) begin nlow_f++; if (c % 3 != 1) bad_low_ph++; end
            if (f_ack0) begin nack_f++; if (c % 3 != 2) bad_ack_ph++; end
            if (f_ack1) bad_ack_ph++;
            if (!f_ram_wen) f_wen_lo++;
            if (!f_ram_oen) f_oen_lo++;
        end
        f_req0 = 0;
        check("t5_low_cnt", nlow_f, 4); check("t5_ack_cnt", nack_f, 4);
        check("t5_low_phase", bad_low_ph, 0); check("t5_ack_phase", bad_ack_ph, 0);
        check("t5_wen_low", f_wen_lo, 0); check("t5_oen_low", f_oen_lo, 4);
        check("t5_rd_data", f_rd_data, 32'h00005A5A);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
